// File: rtl/nrisc_boot_loader.sv
// nRisc boot loader: framed byte stream to instr/data memory writes.
// Holds the core in reset until a RUN header is accepted.
module nrisc_boot_loader (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  input  logic [7:0] InData,
  output logic       InReady,
  output logic       InstrWrite,
  output logic [7:0] InstrAddr,
  output logic [7:0] InstrData,
  output logic       DataWrite,
  output logic [7:0] DataAddr,
  output logic [7:0] DataData,
  output logic       CpuReset,
  output logic       Loaded,
  output logic       ChecksumError
);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_LEN, S_PAY,
    S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic       tgt_q, tgt_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic       err_q, err_d;
  logic       iw_q, iw_d;
  logic [7:0] ia_q, ia_d;
  logic [7:0] id_q, id_d;
  logic       dw_q, dw_d;
  logic [7:0] da_q, da_d;
  logic [7:0] dd_q, dd_d;

  logic       fire;
  logic [7:0] sum;

  assign fire = InValid & InReady;
  assign sum  = acc_q + InData;

  // State and datapath registers; Reset abandons any frame in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_HDR;
      tgt_q   <= 1'b0;
      ptr_q   <= 8'h00;
      cnt_q   <= 9'h000;
      acc_q   <= 8'h00;
      err_q   <= 1'b0;
      iw_q    <= 1'b0;
      ia_q    <= 8'h00;
      id_q    <= 8'h00;
      dw_q    <= 1'b0;
      da_q    <= 8'h00;
      dd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      iw_q    <= iw_d;
      ia_q    <= ia_d;
      id_q    <= id_d;
      dw_q    <= dw_d;
      da_q    <= da_d;
      dd_q    <= dd_d;
    end
  end

  // Next state: frame parsing, checksum and one-cycle write strobes
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    iw_d    = 1'b0;
    ia_d    = ia_q;
    id_d    = id_q;
    dw_d    = 1'b0;
    da_d    = da_q;
    dd_d    = dd_q;
    if (fire) begin
      case (state_q)
        S_HDR: begin
          if (InData == 8'h01 || InData == 8'h02) begin
            tgt_d   = (InData == 8'h01);
            state_d = S_ADDR;
          end else if (InData == 8'hFF) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_ADDR: begin
          ptr_d   = InData;
          acc_d   = InData;
          state_d = S_LEN;
        end
        S_LEN: begin
          cnt_d   = (InData == 8'h00) ? 9'd256
                                      : {1'b0, InData};
          acc_d   = sum;
          state_d = S_PAY;
        end
        S_PAY: begin
          if (tgt_q) begin
            iw_d = 1'b1;
            ia_d = ptr_q;
            id_d = InData;
          end else begin
            dw_d = 1'b1;
            da_d = ptr_q;
            dd_d = InData;
          end
          ptr_d = ptr_q + 8'd1;
          cnt_d = cnt_q - 9'd1;
          acc_d = sum;
          if (cnt_q == 9'd1)
            state_d = S_CSUM;
        end
        S_CSUM: begin
          if (sum == 8'h00) begin
            state_d = S_HDR;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state plus registered write ports
  always_comb begin
    InReady       = (state_q != S_RUN);
    CpuReset      = (state_q != S_RUN);
    Loaded        = (state_q == S_RUN);
    ChecksumError = err_q;
    InstrWrite    = iw_q;
    InstrAddr     = ia_q;
    InstrData     = id_q;
    DataWrite     = dw_q;
    DataAddr      = da_q;
    DataData      = dd_q;
  end

endmodule

// File: tb/tb_nrisc_boot_loader.sv
// Directed bench for nrisc_boot_loader.
// Memory writes are logged at the falling edge and compared to constants.
module tb_nrisc_boot_loader;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       InValid = 1'b0;
  logic [7:0] InData = 8'h00;
  logic       InReady;
  logic       InstrWrite;
  logic [7:0] InstrAddr;
  logic [7:0] InstrData;
  logic       DataWrite;
  logic [7:0] DataAddr;
  logic [7:0] DataData;
  logic       CpuReset;
  logic       Loaded;
  logic       ChecksumError;

  int tests = 0;
  int fails = 0;
  int both  = 0;
  logic [16:0] lg [$];

  nrisc_boot_loader dut (
    .Clock(Clock),
    .Reset(Reset),
    .InValid(InValid),
    .InData(InData),
    .InReady(InReady),
    .InstrWrite(InstrWrite),
    .InstrAddr(InstrAddr),
    .InstrData(InstrData),
    .DataWrite(DataWrite),
    .DataAddr(DataAddr),
    .DataData(DataData),
    .CpuReset(CpuReset),
    .Loaded(Loaded),
    .ChecksumError(ChecksumError)
  );

  always #5 Clock = ~Clock;

  // write log: {is_instr, addr, data}
  always @(negedge Clock) begin
    if (InstrWrite && DataWrite) both++;
    if (InstrWrite) lg.push_back({1'b1, InstrAddr, InstrData});
    if (DataWrite)  lg.push_back({1'b0, DataAddr, DataData});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 32'(InReady), 32'd1);
    chk({tag, "_cpurst"}, 32'(CpuReset), 32'd1);
    chk({tag, "_outs"},
        {InstrWrite, InstrAddr, InstrData, DataWrite,
         DataAddr, DataData, Loaded, ChecksumError},
        32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    InValid = 1'b1;
    InData  = b;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
  endtask

  task automatic send_g(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) begin
      @(posedge Clock);
      #1;
    end
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset;
    Reset   = 1'b1;
    InValid = 1'b0;
    #2;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    lg.delete();
  endtask

  initial begin
    int bad;
    #1;
    chk_rst("reset0");
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    // instruction segment, checksum 0xE7
    send(8'h01); send(8'h00); send(8'h03);
    send(8'hA1); send(8'hB2); send(8'hC3);
    send(8'hE7);
    chk("ins_n", 32'(lg.size()), 32'd3);
    chk("ins_w0", 32'(lg[0]), 32'h1_00A1);
    chk("ins_w1", 32'(lg[1]), 32'h1_01B2);
    chk("ins_w2", 32'(lg[2]), 32'h1_02C3);
    chk("ins_err", 32'(ChecksumError), 32'd0);
    lg.delete();

    // data segment wrapping FE,FF,00, checksum 0x99
    send(8'h02); send(8'hFE); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h99);
    chk("dat_n", 32'(lg.size()), 32'd3);
    chk("dat_w0", 32'(lg[0]), 32'h0_FE11);
    chk("dat_w1", 32'(lg[1]), 32'h0_FF22);
    chk("dat_w2", 32'(lg[2]), 32'h0_0033);
    chk("pre_run_cpurst", 32'(CpuReset), 32'd1);
    send(8'hFF);
    chk("run_cpurst", 32'(CpuReset), 32'd0);
    chk("run_loaded", 32'(Loaded), 32'd1);
    chk("run_rdy", 32'(InReady), 32'd0);
    chk("run_err", 32'(ChecksumError), 32'd0);
    InValid = 1'b1;
    InData  = 8'h07;
    idle(3);
    InValid = 1'b0;
    chk("run_hold", 32'(Loaded), 32'd1);
    chk("run_err2", 32'(ChecksumError), 32'd0);

    // LEN=00 -> 256 bytes, checksum 0x80
    do_reset();
    chk_rst("reset1");
    send(8'h01); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h80);
    chk("len0_n", 32'(lg.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < lg.size(); i++)
      if (lg[i] !== {1'b1, 8'(i), 8'(i)}) bad++;
    chk("len0_content", 32'(bad), 32'd0);
    chk("len0_err", 32'(ChecksumError), 32'd0);
    send(8'hFF);
    chk("len0_run", 32'(Loaded), 32'd1);

    // bad checksum
    do_reset();
    send(8'h01); send(8'h10); send(8'h01);
    send(8'h55); send(8'h00);
    chk("bad_n", 32'(lg.size()), 32'd1);
    chk("bad_w0", 32'(lg[0]), 32'h1_1055);
    chk("bad_err", 32'(ChecksumError), 32'd1);
    chk("bad_rdy", 32'(InReady), 32'd1);
    send(8'hFF);
    chk("bad_cpurst", 32'(CpuReset), 32'd1);
    chk("bad_loaded", 32'(Loaded), 32'd0);
    chk("bad_sticky", 32'(ChecksumError), 32'd1);

    // illegal header
    do_reset();
    chk("hdr_clr", 32'(ChecksumError), 32'd0);
    send(8'h07);
    chk("hdr_err", 32'(ChecksumError), 32'd1);
    send(8'h01); send(8'h00); send(8'h01);
    send(8'h42); send(8'hBD);
    send(8'hFF);
    chk("hdr_nowr", 32'(lg.size()), 32'd0);
    chk("hdr_cpurst", 32'(CpuReset), 32'd1);
    chk("hdr_rdy", 32'(InReady), 32'd1);

    // gapped data segment: 40+05+01+02+03+04+05 = 0x54 -> csum 0xAC
    do_reset();
    send_g(8'h02); send_g(8'h40); send_g(8'h05);
    send_g(8'h01); send_g(8'h02); send_g(8'h03);
    send_g(8'h04); send_g(8'h05); send_g(8'hAC);
    chk("gap_n", 32'(lg.size()), 32'd5);
    chk("gap_w0", 32'(lg[0]), 32'h0_4001);
    chk("gap_w4", 32'(lg[4]), 32'h0_4405);
    chk("gap_err", 32'(ChecksumError), 32'd0);
    lg.delete();

    // reset mid-payload, then a fresh frame
    send_g(8'h01); send_g(8'h20); send_g(8'h04);
    send_g(8'hAA); send_g(8'hBB);
    idle(1);
    Reset = 1'b1;
    #1;
    chk_rst("midrst");
    chk("mid_n", 32'(lg.size()), 32'd2);
    chk("mid_w1", 32'(lg[1]), 32'h1_21BB);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    lg.delete();
    send(8'h01); send(8'h30); send(8'h02);
    send(8'h5A); send(8'hA5); send(8'hCF);
    send(8'hFF);
    chk("fresh_n", 32'(lg.size()), 32'd2);
    chk("fresh_w0", 32'(lg[0]), 32'h1_305A);
    chk("fresh_w1", 32'(lg[1]), 32'h1_31A5);
    chk("fresh_run", 32'(Loaded), 32'd1);
    chk("fresh_err", 32'(ChecksumError), 32'd0);
    chk("both_strobes", 32'(both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
